// File: rtl/game_supervisor_if.sv
// game_supervisor_if
//   Bundles the game-control signals exchanged between the supervisor core and
//   the surrounding blocks: clockdiv, the buttons and switches, the game logic,
//   and the VGA and 7-segment display blocks.
//   Ports (signals):
//     tick           1-cycle game-rate strobe
//     flap_btn       raw flap pushbutton (asynchronous)
//     pause_sw       pause switch level (asynchronous)
//     collision      bird/pillar/ground hit level
//     pillar_passed  per-pillar pass flags, sampled on tick
//     game_state     0=IDLE 1=PLAY 2=PAUSE 3=LOST
//     game_en        physics advance strobe
//     flap_pulse     debounced flap pulse
//     lost           high while in LOST
//     score          current score
//     high_score     best score since reset
//     new_record     1-cycle pulse on high-score update
//   Modports: master drives the inputs of the core; slave is the core itself.
`timescale 1ns/1ps
interface game_supervisor_if #(
    parameter int NUM_PILLARS = 2,
    parameter int SCORE_W     = 10
);
    logic                   tick;
    logic                   flap_btn;
    logic                   pause_sw;
    logic                   collision;
    logic [NUM_PILLARS-1:0] pillar_passed;
    logic [1:0]             game_state;
    logic                   game_en;
    logic                   flap_pulse;
    logic                   lost;
    logic [SCORE_W-1:0]     score;
    logic [SCORE_W-1:0]     high_score;
    logic                   new_record;

    modport master (
        output tick, flap_btn, pause_sw, collision, pillar_passed,
        input  game_state, game_en, flap_pulse, lost, score, high_score, new_record
    );

    modport slave (
        input  tick, flap_btn, pause_sw, collision, pillar_passed,
        output game_state, game_en, flap_pulse, lost, score, high_score, new_record
    );
endinterface

// File: rtl/game_supervisor.sv
// game_supervisor
//   Game-control core for the Flappy Bird design. It provides:
//     - an IDLE/PLAY/PAUSE/LOST state machine
//     - a debounced flap pulse
//     - a saturating score register, incremented by the number of pillars
//       passed per tick
//     - a high-score register with a new-record pulse
//   Every output is registered.
//   Ports:
//     clk    master clock; all logic runs on the rising edge
//     clr_n  synchronous active-low reset
//     bus    game_supervisor_if.slave (see the interface header for signals)
`timescale 1ns/1ps
module game_supervisor #(
    parameter int NUM_PILLARS     = 2,
    parameter int SCORE_W         = 10,
    parameter int MAX_SCORE       = 999,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LOST_HOLD_TICKS = 100
) (
    input  logic                clk,
    input  logic                clr_n,
    game_supervisor_if.slave    bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LOST_HOLD_TICKS + 1);
    localparam int PC_W   = $clog2(NUM_PILLARS + 1);

    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(LOST_HOLD_TICKS);
    localparam logic [SCORE_W:0]   MAX_EXT  = (SCORE_W + 1)'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        LOST  = 2'd3
    } state_t;

    state_t state, state_next;

    logic               flap_sync_p0, flap_sync_p1;
    logic               pause_sync_p0, pause_sync_p1;
    logic               coll_sync_p0, coll_sync_p1;
    logic [DB_W-1:0]    db_cnt;
    logic               flap_db, flap_db_d;
    logic               flap_pulse;
    logic               game_en;
    logic               lost;
    logic               lost_entry;
    logic               new_record;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [SCORE_W-1:0] score, high_score;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_PILLARS-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_PILLARS; i++) begin
            cnt = cnt + PC_W'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [PC_W-1:0]    b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W + 1)'(b);
        if (sum > MAX_EXT) begin
            return MAX_EXT[SCORE_W-1:0];
        end
        return sum[SCORE_W-1:0];
    endfunction

    // Stage p0/p1: two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            flap_sync_p0  <= 1'b0;
            flap_sync_p1  <= 1'b0;
            pause_sync_p0 <= 1'b0;
            pause_sync_p1 <= 1'b0;
            coll_sync_p0  <= 1'b0;
            coll_sync_p1  <= 1'b0;
        end else begin
            flap_sync_p0  <= bus.flap_btn;
            flap_sync_p1  <= flap_sync_p0;
            pause_sync_p0 <= bus.pause_sw;
            pause_sync_p1 <= pause_sync_p0;
            coll_sync_p0  <= bus.collision;
            coll_sync_p1  <= coll_sync_p0;
        end
    end

    // Debounce: the counter runs only while the synced level disagrees with the
    // debounced one, so any return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            db_cnt     <= '0;
            flap_db    <= 1'b0;
            flap_db_d  <= 1'b0;
            flap_pulse <= 1'b0;
        end else begin
            if (flap_sync_p1 != flap_db) begin
                if (db_cnt == DB_LAST) begin
                    flap_db <= flap_sync_p1;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            flap_db_d  <= flap_db;
            flap_pulse <= flap_db & ~flap_db_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flap_pulse) state_next = PLAY;
            end
            PLAY: begin
                if (coll_sync_p1)       state_next = LOST;
                else if (pause_sync_p1) state_next = PAUSE;
            end
            PAUSE: begin
                if (!pause_sync_p1) state_next = PLAY;
            end
            LOST: begin
                if (hold_cnt == HOLD_MAX && flap_pulse) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, score and record registers
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            game_en    <= 1'b0;
            lost       <= 1'b0;
            lost_entry <= 1'b0;
            new_record <= 1'b0;
            hold_cnt   <= '0;
            score      <= '0;
            high_score <= '0;
        end else begin
            state      <= state_next;
            game_en    <= bus.tick && (state == PLAY);
            lost       <= (state_next == LOST);
            lost_entry <= (state != LOST) && (state_next == LOST);

            // A pass on the same tick as a collision still counts because the
            // score update depends only on the current state being PLAY.
            if (state == IDLE && state_next == PLAY) begin
                score <= '0;
            end else if (state == PLAY && bus.tick) begin
                score <= sat_add(score, popcount(bus.pillar_passed));
            end

            if (state == LOST && state_next == LOST) begin
                if (bus.tick && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            // Compare one cycle after entering LOST so the final tick's score is included.
            new_record <= 1'b0;
            if (lost_entry && score > high_score) begin
                high_score <= score;
                new_record <= 1'b1;
            end
        end
    end

    assign bus.game_state = state;
    assign bus.game_en    = game_en;
    assign bus.flap_pulse = flap_pulse;
    assign bus.lost       = lost;
    assign bus.score      = score;
    assign bus.high_score = high_score;
    assign bus.new_record = new_record;

endmodule

// File: tb/tb_game_supervisor.sv
// tb_game_supervisor
//   Directed bench for game_supervisor. The core is run with these parameters:
//     DEBOUNCE_CYCLES = 8
//     MAX_SCORE       = 7
//     LOST_HOLD_TICKS = 3
//   Scoring ticks come from a vector table; multi-cycle scenarios are
//   hand-written sequences.
`timescale 1ns/1ps
module tb_game_supervisor;

    logic clk;
    logic clr_n;

    game_supervisor_if #(.NUM_PILLARS(2), .SCORE_W(10)) bus ();

    game_supervisor #(
        .NUM_PILLARS    (2),
        .SCORE_W        (10),
        .MAX_SCORE      (7),
        .DEBOUNCE_CYCLES(8),
        .LOST_HOLD_TICKS(3)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] pp;
        int         exp_score;
    } vec_t;

    vec_t vecs[16];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses, first;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_tick(input logic [1:0] pp);
        bus.tick          = 1'b1;
        bus.pillar_passed = pp;
        @(negedge clk);
        bus.tick          = 1'b0;
        bus.pillar_passed = 2'b00;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_tick(vecs[i].pp);
            check($sformatf("score_vec%0d", i), bus.score, vecs[i].exp_score);
            check($sformatf("game_en_vec%0d", i), bus.game_en, 1);
        end
    endtask

    task automatic press(input int hold, output int n_p, output int first_k);
        n_p     = 0;
        first_k = -1;
        bus.flap_btn = 1'b1;
        for (int k = 1; k <= hold + 16; k++) begin
            @(negedge clk);
            if (bus.flap_pulse) begin
                n_p++;
                if (first_k < 0) first_k = k;
            end
            if (k == hold) bus.flap_btn = 1'b0;
        end
    endtask

    task automatic collide(input int exp_high, input int exp_rec);
        bus.collision = 1'b1;
        repeat (3) @(negedge clk);
        check("lost_flag", bus.lost, 1);
        check("lost_state", bus.game_state, 3);
        @(negedge clk);
        check("new_record", bus.new_record, exp_rec);
        check("high_score", bus.high_score, exp_high);
        @(negedge clk);
        check("new_record_drop", bus.new_record, 0);
        bus.collision = 1'b0;
    endtask

    task automatic to_idle();
        do_tick(2'b00);
        check("game_en_lost", bus.game_en, 0);
        do_tick(2'b00);
        do_tick(2'b00);
        press(20, pulses, first);
        check("lost_to_idle", bus.game_state, 0);
        check("lost_clear", bus.lost, 0);
    endtask

    task automatic to_play();
        press(20, pulses, first);
        check("idle_to_play", bus.game_state, 1);
        check("score_cleared", bus.score, 0);
    endtask

    initial begin
        vecs[0]  = '{2'b10, 1};
        vecs[1]  = '{2'b01, 2};
        vecs[2]  = '{2'b00, 2};
        vecs[3]  = '{2'b11, 4};
        vecs[4]  = '{2'b11, 2};
        vecs[5]  = '{2'b11, 4};
        vecs[6]  = '{2'b11, 6};
        vecs[7]  = '{2'b11, 2};
        vecs[8]  = '{2'b11, 4};
        vecs[9]  = '{2'b11, 6};
        vecs[10] = '{2'b11, 2};
        vecs[11] = '{2'b11, 2};
        vecs[12] = '{2'b11, 4};
        vecs[13] = '{2'b11, 6};
        vecs[14] = '{2'b11, 7};
        vecs[15] = '{2'b11, 7};

        bus.tick          = 1'b0;
        bus.flap_btn      = 1'b0;
        bus.pause_sw      = 1'b0;
        bus.collision     = 1'b0;
        bus.pillar_passed = 2'b00;
        clr_n             = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", bus.game_state, 0);
        check("rst_score", bus.score, 0);
        check("rst_high", bus.high_score, 0);
        check("rst_game_en", bus.game_en, 0);
        check("rst_lost", bus.lost, 0);
        check("rst_flap_pulse", bus.flap_pulse, 0);
        check("rst_new_record", bus.new_record, 0);
        clr_n = 1'b1;
        @(negedge clk);

        // Short glitch is rejected, and a tick in IDLE does not score.
        press(5, pulses, first);
        check("glitch_pulses", pulses, 0);
        check("glitch_state", bus.game_state, 0);
        do_tick(2'b11);
        check("idle_no_score", bus.score, 0);
        check("idle_game_en", bus.game_en, 0);

        // Full press: exactly one pulse, 11 clocks after the edge.
        press(20, pulses, first);
        check("press_pulses", pulses, 1);
        check("press_latency", first, 11);
        check("press_state", bus.game_state, 1);

        // Game A: score 4, first record, early flap ignored in LOST.
        run_vecs(0, 3);
        @(negedge clk);
        check("game_en_idle_cycle", bus.game_en, 0);
        collide(4, 1);
        do_tick(2'b00);
        press(20, pulses, first);
        check("early_flap_pulse", pulses, 1);
        check("early_flap_ignored", bus.game_state, 3);
        do_tick(2'b00);
        do_tick(2'b00);
        press(20, pulses, first);
        check("hold_expired_idle", bus.game_state, 0);
        to_play();

        // Game B: score 6, pause freezes everything, then new record 6.
        run_vecs(4, 6);
        bus.pause_sw = 1'b1;
        repeat (3) @(negedge clk);
        check("pause_state", bus.game_state, 2);
        bus.collision = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_tick(2'b11);
            check("pause_game_en", bus.game_en, 0);
            check("pause_score", bus.score, 6);
        end
        check("pause_collision_ignored", bus.game_state, 2);
        bus.collision = 1'b0;
        repeat (3) @(negedge clk);
        bus.pause_sw = 1'b0;
        repeat (3) @(negedge clk);
        check("unpause_state", bus.game_state, 1);
        collide(6, 1);
        to_idle();
        to_play();

        // Game C: equal score gives no record.
        run_vecs(7, 9);
        collide(6, 0);
        to_idle();
        to_play();

        // Game D: same-tick collision and pass at score 2.
        run_vecs(10, 10);
        bus.collision = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_collision_state", bus.game_state, 1);
        do_tick(2'b01);
        check("sametick_score", bus.score, 3);
        check("sametick_state", bus.game_state, 3);
        check("sametick_lost", bus.lost, 1);
        @(negedge clk);
        check("sametick_no_record", bus.new_record, 0);
        check("sametick_high", bus.high_score, 6);
        bus.collision = 1'b0;
        to_idle();
        to_play();

        // Game E: saturation at 7, then reset mid-game.
        run_vecs(11, 15);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("midrst_state", bus.game_state, 0);
        check("midrst_score", bus.score, 0);
        check("midrst_high", bus.high_score, 0);
        check("midrst_game_en", bus.game_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
